// File: rtl/mac_array.sv
`default_nettype none
// ============================================================================
// Module   : mac_array
// Brief    : LANES-wide unsigned-feature x signed-weight multiply array with
//            an adder tree and a per-vector accumulator. Beats are summed
//            until in_last, then one dot-product result is emitted over a
//            valid/ready port together with its beat count.
//            Optional saturating accumulation and out_sat flag: define
//            MAC_ARRAY_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mac_array #(
    parameter int LANES = 4,
    parameter int IN_W  = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [LANES*IN_W-1:0] in_feature,
    input  logic [LANES*W_W-1:0]  in_weight,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic [CNT_W-1:0]      out_beats
`ifdef MAC_ARRAY_SAT_EN
    ,
    output logic                  out_sat
`endif
);

    // Product width: 9-bit zero-extended feature times signed weight.
    localparam int c_P_W   = IN_W + W_W + 1;
    // Lane-sum width: enough headroom for LANES products without overflow.
    localparam int c_SUM_W = c_P_W + $clog2(LANES);
    // Accumulate add width: one bit wider than the wider of acc and lane sum,
    // so both the wrap result and the clamp decision are exact.
    localparam int c_EXT_W = ((c_SUM_W > ACC_W) ? c_SUM_W : ACC_W) + 1;

    // Global advance: the whole pipeline moves unless a result is stuck.
    logic w_adv;
    assign w_adv    = !(out_valid && !out_ready);
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // S0: input capture
    // ------------------------------------------------------------------
    logic                  r_s0_valid;
    logic                  r_s0_last;
    logic [LANES*IN_W-1:0] r_s0_feat;
    logic [LANES*W_W-1:0]  r_s0_wt;

    // Register an accepted beat; a non-accepted cycle becomes a zeroed bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_feat  <= '0;
            r_s0_wt    <= '0;
        end else if (w_adv) begin
            r_s0_valid <= in_valid;
            r_s0_last  <= in_valid & in_last;
            r_s0_feat  <= in_valid ? in_feature : '0;
            r_s0_wt    <= in_valid ? in_weight  : '0;
        end
    end

    // ------------------------------------------------------------------
    // S1: per-lane signed products
    // ------------------------------------------------------------------
    logic [LANES*c_P_W-1:0] w_prod;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [c_P_W-1:0] w_f_ext;
            logic [c_P_W-1:0] w_w_ext;
            // Feature is zero-extended, weight sign-extended, to product width.
            assign w_f_ext = {{(W_W + 1){1'b0}}, r_s0_feat[gi*IN_W +: IN_W]};
            assign w_w_ext = {{(IN_W + 1){r_s0_wt[gi*W_W + W_W - 1]}},
                              r_s0_wt[gi*W_W +: W_W]};
            assign w_prod[gi*c_P_W +: c_P_W] = $signed(w_f_ext) * $signed(w_w_ext);
        end
    endgenerate

    logic                   r_s1_valid;
    logic                   r_s1_last;
    logic [LANES*c_P_W-1:0] r_s1_prod;

    // Register lane products; bubbles carry zero products.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_prod  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= r_s0_valid;
            r_s1_last  <= r_s0_last;
            r_s1_prod  <= r_s0_valid ? w_prod : '0;
        end
    end

    // ------------------------------------------------------------------
    // S2: lane sum
    // ------------------------------------------------------------------
    logic signed [c_SUM_W-1:0] w_tree;

    // Sign-extend every product to the tree width and add them up.
    always_comb begin
        w_tree = '0;
        for (int i = 0; i < LANES; i++) begin
            w_tree = w_tree + c_SUM_W'($signed(r_s1_prod[i*c_P_W +: c_P_W]));
        end
    end

    logic                      r_s2_valid;
    logic                      r_s2_last;
    logic signed [c_SUM_W-1:0] r_s2_sum;

    // Register the beat sum alongside its valid/last flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_sum   <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_valid & r_s1_last;
            r_s2_sum   <= r_s1_valid ? w_tree : '0;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator and beat counter
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_acc_empty;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [ACC_W-1:0]   w_acc_base;
    logic signed [c_EXT_W-1:0] w_full;
    logic [ACC_W-1:0]          w_acc_next;
    logic [CNT_W-1:0]          w_cnt_next;

    // A first beat starts from zero so the previous vector never leaks in.
    assign w_acc_base = r_acc_empty ? '0 : r_acc;
    assign w_full     = c_EXT_W'(w_acc_base) + c_EXT_W'(r_s2_sum);
    assign w_cnt_next = r_cnt + CNT_W'(1);

`ifdef MAC_ARRAY_SAT_EN
    localparam logic signed [c_EXT_W-1:0] c_ACC_MAX =
        {{(c_EXT_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
    localparam logic signed [c_EXT_W-1:0] c_ACC_MIN =
        {{(c_EXT_W - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};

    logic w_clamp;
    logic r_sat_any;

    // Clamp the exact sum into the signed ACC_W range and flag when it hits.
    always_comb begin
        w_clamp    = 1'b0;
        w_acc_next = w_full[ACC_W-1:0];
        if (w_full > c_ACC_MAX) begin
            w_clamp    = 1'b1;
            w_acc_next = c_ACC_MAX[ACC_W-1:0];
        end else if (w_full < c_ACC_MIN) begin
            w_clamp    = 1'b1;
            w_acc_next = c_ACC_MIN[ACC_W-1:0];
        end
    end

    // Remember whether any beat of the current vector saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_any <= 1'b0;
        end else if (w_adv && r_s2_valid) begin
            r_sat_any <= r_s2_last ? 1'b0 : (r_sat_any | w_clamp);
        end
    end
`else
    // Plain two's-complement wrap: keep the low ACC_W bits.
    assign w_acc_next = w_full[ACC_W-1:0];
`endif

    // Fold each valid beat into the accumulator; a last beat re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_acc_empty <= 1'b1;
            r_cnt       <= '0;
        end else if (w_adv && r_s2_valid) begin
            r_acc <= w_acc_next;
            if (r_s2_last) begin
                r_acc_empty <= 1'b1;
                r_cnt       <= '0;
            end else begin
                r_acc_empty <= 1'b0;
                r_cnt       <= w_cnt_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result register
    // ------------------------------------------------------------------
    // Load a finished vector; otherwise drop valid once it was taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
`ifdef MAC_ARRAY_SAT_EN
            out_sat   <= 1'b0;
`endif
        end else if (w_adv) begin
            if (r_s2_valid && r_s2_last) begin
                out_valid <= 1'b1;
                out_data  <= w_acc_next;
                out_beats <= w_cnt_next;
`ifdef MAC_ARRAY_SAT_EN
                out_sat   <= r_sat_any | w_clamp;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_array
// Brief    : Self-checking bench for mac_array: directed cases with literal
//            expectations plus randomized vectors against a dot-product
//            reference model with a result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_array;

    localparam int LANES = 4;
    localparam int IN_W  = 8;
    localparam int W_W   = 8;
    localparam int ACC_W = 24;
    localparam int CNT_W = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic                  in_last = 1'b0;
    logic [LANES*IN_W-1:0] in_feature = '0;
    logic [LANES*W_W-1:0]  in_weight = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [ACC_W-1:0]      out_data;
    logic [CNT_W-1:0]      out_beats;
`ifdef MAC_ARRAY_SAT_EN
    logic                  out_sat;
`endif

    mac_array #(
        .LANES(LANES), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_feature(in_feature),
        .in_weight (in_weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats)
`ifdef MAC_ARRAY_SAT_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint data;
        int     beats;
        bit     sat;
    } res_t;

    res_t   exp_q[$];
    longint m_acc   = 0;
    int     m_beats = 0;
    bit     m_sat   = 0;

    function automatic longint beat_sum(input logic [LANES*IN_W-1:0] f,
                                        input logic [LANES*W_W-1:0] w);
        longint s = 0;
        for (int i = 0; i < LANES; i++) begin
            logic [IN_W-1:0]        fi;
            logic signed [W_W-1:0]  wi;
            fi = f[i*IN_W +: IN_W];
            wi = w[i*W_W +: W_W];
            s += longint'(fi) * longint'(wi);
        end
        return s;
    endfunction

    function automatic longint wrap_acc(input longint v);
        longint m = (64'sd1 <<< ACC_W);
        longint r = v % m;
        if (r < 0) r += m;
        if (r >= (m / 2)) r -= m;
        return r;
    endfunction

    task automatic model_accept(input logic [LANES*IN_W-1:0] f,
                                input logic [LANES*W_W-1:0] w, input logic last);
        longint t;
        longint hi = (64'sd1 <<< (ACC_W - 1)) - 1;
        longint lo = -(64'sd1 <<< (ACC_W - 1));
        t = m_acc + beat_sum(f, w);
`ifdef MAC_ARRAY_SAT_EN
        if (t > hi) begin t = hi; m_sat = 1; end
        else if (t < lo) begin t = lo; m_sat = 1; end
`else
        t = wrap_acc(t);
`endif
        m_acc = t;
        m_beats++;
        if (last) begin
            res_t r;
            r.data  = m_acc;
            r.beats = m_beats % (1 << CNT_W);
            r.sat   = m_sat;
            exp_q.push_back(r);
            m_acc   = 0;
            m_beats = 0;
            m_sat   = 0;
        end
    endtask

    // ---------------- monitor / compare process ----------------
    bit               rst_prev  = 1'b1;
    bit               hold_prev = 1'b0;
    logic [ACC_W-1:0] held_data;
    logic [CNT_W-1:0] held_beats;

    // Every negedge: reset values, ready rule, output hold, model compare.
    always @(negedge clk) begin
        if (rst) begin
            if (rst_prev) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_out_data", out_data, 0);
                check("rst_out_beats", out_beats, 0);
            end
            m_acc = 0; m_beats = 0; m_sat = 0;
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held_data);
                check("hold_beats", out_beats, held_beats);
            end
            if (in_valid && in_ready)
                model_accept(in_feature, in_weight, in_last);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_result: got data %0d, required no result",
                             $signed(out_data));
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("model_data", 64'($signed(out_data)), r.data);
                    check("model_beats", out_beats, r.beats);
`ifdef MAC_ARRAY_SAT_EN
                    check("model_sat", out_sat, r.sat);
`endif
                end
            end
            hold_prev  = out_valid && !out_ready;
            held_data  = out_data;
            held_beats = out_beats;
        end
        rst_prev = rst;
    end

    // ---------------- random backpressure ----------------
    bit rand_rdy = 1'b0;
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send_beat(input logic [LANES*IN_W-1:0] f,
                             input logic [LANES*W_W-1:0] w,
                             input logic last, input int gap);
        bit ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_feature = f;
        in_weight  = w;
        in_last    = last;
        in_valid   = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready 0 for 200 cycles, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string name, input longint exp_data, input int exp_beats);
        bit ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: no result in 100 cycles, required one", name);
        end else begin
            check({name, "_data"}, 64'($signed(out_data)), exp_data);
            check({name, "_beats"}, out_beats, exp_beats);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Lane 0 is the least significant byte.
    localparam logic [31:0] c_F_1234 = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] c_ONES   = {8'd1, 8'd1, 8'd1, 8'd1};

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        check("valid_after_rst", out_valid, 0);
        @(posedge clk); #1;

        // Latency and single-cycle pulse.
        send_beat(c_F_1234, c_ONES, 1'b1, 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("lat_valid_e%0d", k), out_valid, (k == 3));
            if (k == 3) begin
                check("lat_data", 64'($signed(out_data)), 10);
                check("lat_beats", out_beats, 1);
            end
        end
        drain();

        // Signed two-beat vector.
        send_beat(32'hFFFF_FFFF, 32'h8080_8080, 1'b0, 0);
        send_beat(32'hFFFF_FFFF, 32'h8080_8080, 1'b1, 0);
        wait_out("signed2", -261120, 2);
        drain();

        // Back-to-back single-beat vectors.
        send_beat(c_F_1234, c_ONES, 1'b1, 0);
        send_beat(c_ONES, c_ONES, 1'b1, 0);
        wait_out("b2b_a", 10, 1);
        @(negedge clk);
        check("b2b_b_valid", out_valid, 1);
        check("b2b_b_data", 64'($signed(out_data)), 4);
        drain();

        // Backpressure: result held 5 cycles while input streams.
        out_ready = 1'b0;
        fork
            begin
                send_beat(c_F_1234, c_ONES, 1'b1, 0);
                send_beat(c_ONES, c_ONES, 1'b0, 0);
                send_beat(c_F_1234, c_ONES, 1'b1, 0);
                send_beat(c_ONES, c_ONES, 1'b1, 0);
            end
            begin
                bit seen = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (out_valid) begin seen = 1'b1; break; end
                end
                check("bp_seen", seen, 1);
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_data", 64'($signed(out_data)), 10);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                wait_out("bp_a", 10, 1);
            end
        join
        wait_out("bp_b", 14, 2);
        wait_out("bp_c", 4, 1);
        drain();

        // Reset mid-vector discards the partial sum.
        send_beat(c_F_1234, c_ONES, 1'b0, 0);
        send_beat(c_F_1234, c_ONES, 1'b0, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_beat(c_ONES, c_ONES, 1'b1, 0);
        wait_out("rstmid", 4, 1);
        drain();

        // Zero-data last beat still emits.
        send_beat(32'h0, 32'h7F7F_7F7F, 1'b1, 1);
        wait_out("zero", 0, 1);
        drain();

        // Long positive vector that overflows the accumulator.
        for (int b = 0; b < 70; b++)
            send_beat(32'hFFFF_FFFF, 32'h7F7F_7F7F, (b == 69), 0);
`ifdef MAC_ARRAY_SAT_EN
        wait_out("ovf", 8388607, 70);
        check("ovf_sat", out_sat, 1);
`else
        wait_out("ovf", -7709416, 70);
`endif
        drain();

        // Randomized vectors, gaps and backpressure.
        rand_rdy = 1'b1;
        for (int v = 0; v < 150; v++) begin
            int len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                logic [31:0] f = $urandom();
                logic [31:0] w = $urandom();
                if ($urandom_range(0, 9) == 0) begin
                    f = 32'hFFFF_FFFF;
                    w = ($urandom_range(0, 1) != 0) ? 32'h8080_8080 : 32'h7F7F_7F7F;
                end
                send_beat(f, w, (b == len - 1),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mac_array.md
Name: mac_array

Overview:
- Parametrised successor to the single-lane 2-stage multiplier.
- LANES parallel unsigned-feature × signed-weight multipliers feed an adder tree and a vector accumulator.
- The accumulator sums beats until `in_last`, then emits one accumulated dot-product result with valid/ready handshake.
- Sits between the feature/weight streamers and the neuron activation/argmax stage of the MNIST datapath.

Parameters:
- LANES, 4: parallel multiply lanes per beat.
- IN_W, 8: input feature width, unsigned.
- W_W, 8: weight width, signed two's complement.
- ACC_W, 24: accumulator and result width, signed.
- CNT_W, 16: beat-counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready at a clk edge.
- in_last  in  1  beat is final beat of current vector.
- in_feature  in  LANES*IN_W  lane i at bits [i*IN_W +: IN_W], unsigned.
- in_weight  in  LANES*W_W  lane i at bits [i*W_W +: W_W], signed.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  signed accumulated dot product of the vector.
- out_beats  out  CNT_W  number of beats in the emitted vector.

Behaviour:
- Reset: synchronous, active-high. At a clk edge with rst=1:
  - out_valid=0, out_data=0, out_beats=0.
  - All pipeline valid bits, last bits and data registers cleared; accumulator=0; beat counter=0.
  - in_ready=1 the cycle after rst deasserts.
- Stall: `adv = !(out_valid && !out_ready)`. in_ready = adv. When adv=0 every pipeline stage holds and no beat is accepted.
- S0, registered on accept: feature, weight, last, valid. A non-accepted cycle inserts a bubble (valid=0, data zeroed).
- S1, products: p_i = {1'b0,feature_i} × weight_i, signed, width IN_W+W_W+1. Bubbles produce 0.
- S2, lane sum: the adder tree sums the LANES products, sign-extended to ACC_W.
  - If this is the first beat of a vector (accumulator empty flag), acc = sum; otherwise acc = acc + sum, wrapping modulo 2^ACC_W.
  - The beat counter increments per valid beat.
- Emit: when the S2 beat has last=1:
  - out_data ← final acc, out_beats ← count, out_valid ← 1.
  - Accumulator-empty flag set, counter cleared the same edge.
- Latency: out_valid rises 3 clk edges after the edge accepting the last beat, with no stall.
- Back-to-back vectors: a first beat of vector N+1 directly after the last beat of vector N loads fresh. There is no contamination and no bubble required.
- Throughput: one beat/cycle while out_ready=1. A result may be emitted every cycle for single-beat vectors.
- Output hold: out_data and out_beats are stable while out_valid && !out_ready. out_valid clears on handshake unless a new result lands on the same edge.
- Reset mid-vector: the partial accumulation is discarded. The first beat after reset starts a new vector.
- in_last on a zero-data beat is legal; it contributes 0 and still emits.
- out_beats wraps modulo 2^CNT_W.
- in_valid=0 beats never alter the accumulator or counter.

Optional Feature:
- Macro MAC_ARRAY_SAT_EN.
- Defined:
  - The S2 add is computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on every beat; the saturated value is retained for later beats.
  - An extra output port `out_sat` (1 bit) is asserted with out_valid when any beat of that vector clamped; reset value 0.
- Undefined: the accumulation wraps two's complement, and `out_sat` does not exist.

Test Plan (LANES=4, IN_W=8, W_W=8, CNT_W=16; ACC_W=24 unless noted):
- Single beat, features {1,2,3,4}, weights {1,1,1,1}, last=1, out_ready=1 → out_valid exactly 3 edges later, out_data=10, out_beats=1, single-cycle pulse.
- Signed two-beat vector, all features 255, all weights -128 → out_data=-261120, out_beats=2.
- Back-to-back single-beat vectors A (sum 10) then B (features {1,1,1,1}, weights {1,1,1,1}) → consecutive out_valid cycles with out_data 10 then 4.
- Backpressure:
  - Stimulus: out_ready held low 5 cycles while a result is pending, with the input streaming.
  - Response: in_ready=0 and out_data stable throughout; after release, all vectors emerge in order with correct sums; no beat lost or duplicated.
- Reset mid-vector: 2 beats of sum 10 accepted, rst pulse, then a single beat of sum 4 with last → out_data=4, out_beats=1; outputs 0 during reset.
- ACC_W=16, two beats with all features 255, weights 127, last on beat 2:
  - With MAC_ARRAY_SAT_EN: out_data=32767, out_sat=1.
  - Without: out_data=-3064 (259080 mod 2^16).
